m_pc_unit: RTL and testbench
============================

Name: m_pc_unit

Overview:
- Parametrised next-generation program counter for the fetch stage of the multi-cycle cache core.
- Adds configurable width, reset/exception vectors, signed branch offsets, exception PC (EPC) save/return, and a circular return-address stack (RAS) for call/return.
- Drives the instruction-cache fetch address. Redirect inputs come from decode/execute; exception inputs come from the panic logic.

Parameters:
- XLEN, 32, PC and target width in bits (>= 16).
- BR_OFF_W, 13, width of the signed word branch offset.
- RAS_DEPTH, 4, RAS entries (power of 2, >= 2).
- RESET_VECTOR, 0, PC value after reset (word aligned).
- EXC_VECTOR, 32'h0FFFFFF0, PC value loaded on panic (word aligned).

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  freeze PC/RAS/EPC
- branch  in  1  take PC-relative branch
- branch_off  in  BR_OFF_W  signed word offset
- jump  in  1  absolute jump
- jump_target  in  XLEN  word index of target
- call  in  1  jump to jump_target and push return address
- ret  in  1  return via RAS
- ret_target  in  XLEN  byte address used when the RAS is empty
- panic  in  1  exception entry
- eret  in  1  exception return
- pc_out  out  XLEN  current PC
- epc_out  out  XLEN  saved exception PC
- redirect  out  1  PC was loaded non-sequentially on the last update
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_empty  out  1  ras_count == 0
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_underflow  out  1  one-cycle pulse: ret with empty RAS

Behaviour:
- Reset (synchronous):
  - pc_out = RESET_VECTOR, epc_out = 0.
  - redirect = 0, ras_count = 0, ras_underflow = 0, RAS pointer = 0.
  - RAS entry contents are don't-care.
- Update priority, one cycle per update, single-cycle latency (new PC visible the cycle after the edge):
  1. reset
  2. panic: epc <= pc_out; PC <= EXC_VECTOR. Panic is honoured even when stall = 1.
  3. stall: all state holds; redirect <= 0; ras_underflow <= 0.
  4. eret: PC <= epc.
  5. branch: PC <= PC + (sign_extend(branch_off) << 2), wrapping modulo 2^XLEN.
  6. jump or call: PC <= {jump_target[XLEN-3:0], 2'b00}.
     - A call also pushes PC + 4.
  7. ret:
     - RAS non-empty: PC <= top entry; pop.
     - RAS empty: PC <= {ret_target[XLEN-1:2], 2'b00}; ras_underflow <= 1.
  8. otherwise: PC <= PC + 4, wrapping modulo 2^XLEN.
- A call is a jump for PC purposes. The push happens only when call is the winning source.
- call and ret asserted together: treated as call; no pop.
- A lower-priority request that loses arbitration is dropped, with no side effects on RAS or EPC.
- redirect <= 1 when the selected source is priorities 2 or 4–7; 0 for sequential, stall, or reset.
- RAS organisation:
  - Circular buffer with a top pointer.
  - Push writes the next slot and advances the pointer; ras_count saturates at RAS_DEPTH.
  - On overflow the oldest entry is overwritten silently.
  - Pop reads the top and retreats the pointer; ras_count decrements.
- Panic and eret do not touch the RAS.
- A nested panic overwrites the EPC; there is no EPC stack.
- All outputs are registered. Combinational paths exist only from the inputs to next-state logic.

Test Plan:
- Reset then 3 free-running cycles → pc_out = 0, 4, 8, 0x0C; redirect = 0. Assert reset mid-stream with stall = 1 → pc_out = RESET_VECTOR the next cycle.
- At PC = 0x100, branch = 1, branch_off = -4 (13'h1FFC) → pc_out = 0x0F0, redirect = 1. Same cycle with jump = 1 also asserted → branch wins, pc_out = 0x0F0.
- At PC = 0x40, call with jump_target = 0x100 → pc_out = 0x400, ras_count = 1. Then ret → pc_out = 0x44, ras_empty = 1.
- Five calls with RAS_DEPTH = 4 → ras_full = 1, ras_count = 4. Four rets return the last four return addresses, newest first. A fifth ret with ret_target = 0x2000 → pc_out = 0x2000, ras_underflow pulses for one cycle.
- At PC = 0x80, panic with stall = 1 → pc_out = 0x0FFFFFF0, epc_out = 0x80. Then eret → pc_out = 0x80, redirect = 1.
- stall held for 3 cycles with branch/call/ret toggling → pc_out, ras_count and epc_out unchanged; redirect = 0.

Source files
------------

// File: rtl/m_pc_unit.sv
// Fetch-stage program counter: prioritised redirects, exception PC save/return,
// and a circular return-address stack for call/return.
module m_pc_unit #(
    parameter int              XLEN         = 32,
    parameter int              BR_OFF_W     = 13,
    parameter int              RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h0FFF_FFF0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch,
    input  logic [BR_OFF_W-1:0]        branch_off,
    input  logic                       jump,
    input  logic [XLEN-1:0]            jump_target,
    input  logic                       call,
    input  logic                       ret,
    input  logic [XLEN-1:0]            ret_target,
    input  logic                       panic,
    input  logic                       eret,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            epc_out,
    output logic                       redirect,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] epc_q, epc_n;
    logic            redirect_q, redirect_n;
    logic            underflow_q, underflow_n;
    logic [PW-1:0]   ras_ptr_q, ras_ptr_n;
    logic [CW-1:0]   ras_count_q, ras_count_n;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic            push, pop;

    logic [XLEN-1:0] pc_seq, br_off_ext, br_target, jmp_target, ret_fallback;
    logic            unused_bits;

    assign pc_seq       = pc_q + XLEN'(4);
    assign br_off_ext   = {{(XLEN-BR_OFF_W){branch_off[BR_OFF_W-1]}}, branch_off};
    assign br_target    = pc_q + (br_off_ext << 2);
    assign jmp_target   = {jump_target[XLEN-3:0], 2'b00};
    assign ret_fallback = {ret_target[XLEN-1:2], 2'b00};
    assign unused_bits  = ^{jump_target[XLEN-1:XLEN-2], ret_target[1:0]};

    always_comb begin
        pc_n        = pc_seq;
        epc_n       = epc_q;
        redirect_n  = 1'b0;
        underflow_n = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        ras_ptr_n   = ras_ptr_q;
        ras_count_n = ras_count_q;

        if (panic) begin
            epc_n      = pc_q;
            pc_n       = EXC_VECTOR;
            redirect_n = 1'b1;
        end else if (stall) begin
            pc_n = pc_q;
        end else if (eret) begin
            pc_n       = epc_q;
            redirect_n = 1'b1;
        end else if (branch) begin
            pc_n       = br_target;
            redirect_n = 1'b1;
        end else if (jump || call) begin
            pc_n       = jmp_target;
            redirect_n = 1'b1;
            push       = call;
        end else if (ret) begin
            redirect_n = 1'b1;
            if (ras_count_q != '0) begin
                pc_n = ras_mem[ras_ptr_q];
                pop  = 1'b1;
            end else begin
                pc_n        = ret_fallback;
                underflow_n = 1'b1;
            end
        end

        // Push past a full stack overwrites the oldest slot; the count saturates.
        if (push) begin
            ras_ptr_n = ras_ptr_q + PW'(1);
            if (ras_count_q != CW'(RAS_DEPTH))
                ras_count_n = ras_count_q + CW'(1);
        end else if (pop) begin
            ras_ptr_n   = ras_ptr_q - PW'(1);
            ras_count_n = ras_count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            epc_q       <= '0;
            redirect_q  <= 1'b0;
            underflow_q <= 1'b0;
            ras_ptr_q   <= '0;
            ras_count_q <= '0;
        end else begin
            pc_q        <= pc_n;
            epc_q       <= epc_n;
            redirect_q  <= redirect_n;
            underflow_q <= underflow_n;
            ras_ptr_q   <= ras_ptr_n;
            ras_count_q <= ras_count_n;
        end
    end

    // Stack contents carry no reset; only the pointer and count do.
    always_ff @(posedge clk) begin
        if (!reset && push)
            ras_mem[ras_ptr_n] <= pc_seq;
    end

    assign pc_out        = pc_q;
    assign epc_out       = epc_q;
    assign redirect      = redirect_q;
    assign ras_count     = ras_count_q;
    assign ras_empty     = (ras_count_q == '0);
    assign ras_full      = (ras_count_q == CW'(RAS_DEPTH));
    assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_m_pc_unit.sv
// Directed bench for m_pc_unit: each step queues the expected PC, then the
// value is popped and compared once the clock edge has updated the DUT.
module tb_m_pc_unit;

    localparam int XLEN = 32;
    localparam int BR_OFF_W = 13;
    localparam int RAS_DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset, stall, branch, jump, call, ret, panic, eret;
    logic [BR_OFF_W-1:0] branch_off;
    logic [XLEN-1:0]     jump_target, ret_target;
    logic [XLEN-1:0]     pc_out, epc_out;
    logic                redirect, ras_empty, ras_full, ras_underflow;
    logic [2:0]          ras_count;

    logic [XLEN-1:0] exp_q[$];
    logic            exp_rd_q[$];
    int              n_checks = 0;
    int              n_pass = 0;

    m_pc_unit #(
        .XLEN(XLEN), .BR_OFF_W(BR_OFF_W), .RAS_DEPTH(RAS_DEPTH),
        .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h0FFF_FFF0)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .branch_off(branch_off), .jump(jump), .jump_target(jump_target),
        .call(call), .ret(ret), .ret_target(ret_target), .panic(panic),
        .eret(eret), .pc_out(pc_out), .epc_out(epc_out), .redirect(redirect),
        .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_underflow(ras_underflow)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        stall = 0; branch = 0; jump = 0; call = 0; ret = 0; panic = 0; eret = 0;
        branch_off = '0; jump_target = '0; ret_target = '0;
    endtask

    // driver: inputs are already set; queue expectation, clock, compare
    task automatic step(input string tag, input logic [31:0] exp_pc, input logic exp_rd);
        exp_q.push_back(exp_pc);
        exp_rd_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_pc"}, pc_out, exp_q.pop_front());
            check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, exp_rd_q.pop_front()});
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_pc", pc_out, 32'h0);
        check("rst_epc", epc_out, 32'h0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_count", {29'd0, ras_count}, 32'd0);
        check("rst_empty", {31'd0, ras_empty}, 32'd1);
        check("rst_full", {31'd0, ras_full}, 32'd0);
        check("rst_uflow", {31'd0, ras_underflow}, 32'd0);
        reset = 0;

        step("seq1", 32'h4, 0);
        step("seq2", 32'h8, 0);
        step("seq3", 32'hC, 0);
        reset = 1; stall = 1;
        step("mid_reset", 32'h0, 0);
        reset = 0;

        jump = 1; jump_target = 32'h40;
        step("jmp100", 32'h100, 1);
        branch = 1; branch_off = 13'h1FFC; jump = 1; jump_target = 32'h999;
        step("branch_neg", 32'hF0, 1);

        jump = 1; jump_target = 32'h10;
        step("jmp40", 32'h40, 1);
        call = 1; jump_target = 32'h100;
        step("call1", 32'h400, 1);
        check("call1_count", {29'd0, ras_count}, 32'd1);
        ret = 1;
        step("ret1", 32'h44, 1);
        check("ret1_empty", {31'd0, ras_empty}, 32'd1);

        call = 1; jump_target = 32'h200; step("c1", 32'h800, 1);
        call = 1; jump_target = 32'h300; step("c2", 32'hC00, 1);
        call = 1; jump_target = 32'h400; step("c3", 32'h1000, 1);
        call = 1; jump_target = 32'h500; step("c4", 32'h1400, 1);
        call = 1; jump_target = 32'h600; step("c5", 32'h1800, 1);
        check("c5_full", {31'd0, ras_full}, 32'd1);
        check("c5_count", {29'd0, ras_count}, 32'd4);
        ret = 1; step("r1", 32'h1404, 1);
        ret = 1; step("r2", 32'h1004, 1);
        ret = 1; step("r3", 32'hC04, 1);
        ret = 1; step("r4", 32'h804, 1);
        check("r4_count", {29'd0, ras_count}, 32'd0);
        ret = 1; ret_target = 32'h2003;
        step("r5_uflow", 32'h2000, 1);
        check("r5_uflow_pulse", {31'd0, ras_underflow}, 32'd1);
        step("after_uflow", 32'h2004, 0);
        check("uflow_clear", {31'd0, ras_underflow}, 32'd0);

        call = 1; ret = 1; jump_target = 32'h10; ret_target = 32'h3000;
        step("call_ret", 32'h40, 1);
        check("call_ret_count", {29'd0, ras_count}, 32'd1);
        ret = 1;
        step("call_ret_pop", 32'h2008, 1);

        jump = 1; jump_target = 32'h20;
        step("jmp80", 32'h80, 1);
        panic = 1; stall = 1;
        step("panic", 32'h0FFF_FFF0, 1);
        check("panic_epc", epc_out, 32'h80);
        eret = 1;
        step("eret", 32'h80, 1);

        call = 1; jump_target = 32'h40;
        step("pre_stall_call", 32'h100, 1);
        for (int i = 0; i < 3; i++) begin
            stall = 1;
            branch = 1'($urandom_range(0, 1));
            branch_off = 13'($urandom_range(0, 8191));
            call = 1'($urandom_range(0, 1));
            ret = 1'($urandom_range(0, 1));
            jump_target = $urandom_range(0, 32'h0FFF_FFFF);
            step("stall", 32'h100, 0);
            check("stall_count", {29'd0, ras_count}, 32'd1);
            check("stall_epc", epc_out, 32'h80);
        end
        step("post_stall", 32'h104, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
